// File: rtl/fir_sink_pkg.sv
// Shared widths and defaults for the FIR output sink.
// Holds sample/FIFO defaults, statistic widths and pointer-width helper.
package fir_sink_pkg;

  localparam int DW_DEF    = 11;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W     = 16;
  localparam int SUM_W     = 24;
  localparam int PTR_W_DEF = $clog2(DEPTH_DEF);

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fir_sink_fifo.sv
// Capture FIFO for the FIR output sink (storage, pointers, level).
// Ports: clk, rst (async active-low), push/din, pop/dout, not_empty, level_nxt.
module fir_sink_fifo
  import fir_sink_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              din,
  input  logic                       pop,
  output logic [DW-1:0]              dout,
  output logic                       not_empty,
  output logic [ptr_w(DEPTH):0]      level_nxt
);

  localparam int PW = ptr_w(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   level_q, level_d;
  logic          do_pop;

  assign not_empty = (level_q != '0);
  assign do_pop    = pop & not_empty;
  // Head is masked so rd_data reads zero whenever the FIFO is empty.
  assign dout      = not_empty ? mem_q[rd_ptr_q] : '0;
  assign level_nxt = level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/fir_dout_sink.sv
// FIR output sink: capture FIFO with registered backpressure and stats.
// Ports: clk, rst (async active-low), dout_data/dout_vld/dout_busy from the
// FIR, rd_en/rd_data/rd_vld downstream, clr_stats, sample_cnt, acc_sum,
// sum_ovf. Optional macro FIR_SINK_THROTTLE_EN limits intake to 1 per 2 cycles.
module fir_dout_sink
  import fir_sink_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     dout_data,
  input  logic              dout_vld,
  output logic              dout_busy,
  input  logic              rd_en,
  output logic [DW-1:0]     rd_data,
  output logic              rd_vld,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [SUM_W-1:0]  acc_sum,
  output logic              sum_ovf
);

  localparam int PW = ptr_w(DEPTH);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [SUM_W:0]   add;
  logic             push, pop, full_nxt;
  logic [PW:0]      level_nxt;

  assign push = dout_vld & ~busy_q;
  assign pop  = rd_en & rd_vld;

  fir_sink_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .din       (dout_data),
    .pop       (pop),
    .dout      (rd_data),
    .not_empty (rd_vld),
    .level_nxt (level_nxt)
  );

  assign full_nxt = (level_nxt == (PW+1)'(DEPTH));

`ifdef FIR_SINK_THROTTLE_EN
  logic phase_q, phase_d;

  assign phase_d = ~phase_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) phase_q <= 1'b0;
    else      phase_q <= phase_d;
  end

  // Busy follows the phase that is current at this edge: 0,1,0,1...
  always_comb busy_d = full_nxt | phase_q;
`else
  always_comb busy_d = full_nxt;
`endif

  // A clear and an accept in the same cycle restart from the new sample.
  always_comb begin
    cnt_d = cnt_q;
    sum_d = sum_q;
    ovf_d = ovf_q;
    add   = '0;
    if (clr_stats) begin
      cnt_d = '0;
      sum_d = '0;
      ovf_d = 1'b0;
    end
    if (push) begin
      cnt_d = cnt_d + 1'b1;
      add   = {1'b0, sum_d} + (SUM_W+1)'(dout_data);
      sum_d = add[SUM_W-1:0];
      ovf_d = ovf_d | add[SUM_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      sum_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dout_busy  = busy_q;
  assign sample_cnt = cnt_q;
  assign acc_sum    = sum_q;
  assign sum_ovf    = ovf_q;

endmodule

// File: tb/tb_fir_dout_sink.sv
// Self-checking bench for fir_dout_sink against a queue-based model.
// Directed scenarios followed by randomized traffic.
module tb_fir_dout_sink;

  localparam int DW    = 11;
  localparam int DEPTH = 4;

`ifdef FIR_SINK_THROTTLE_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] dout_data;
  logic          dout_vld;
  logic          dout_busy;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_vld;
  logic          clr_stats;
  logic [15:0]   sample_cnt;
  logic [23:0]   acc_sum;
  logic          sum_ovf;

  fir_dout_sink #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .dout_data  (dout_data),
    .dout_vld   (dout_vld),
    .dout_busy  (dout_busy),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_vld     (rd_vld),
    .clr_stats  (clr_stats),
    .sample_cnt (sample_cnt),
    .acc_sum    (acc_sum),
    .sum_ovf    (sum_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state
  int unsigned q[$];
  int unsigned m_cnt;
  longint      m_sum;
  bit          m_ovf;
  bit          m_busy;
  int          m_edges;
  bit          last_acc;
  int          n_acc;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clr();
    m_cnt = 0;
    m_sum = 0;
    m_ovf = 1'b0;
  endtask

  task automatic cyc(input logic v, input int unsigned d,
                     input logic r, input logic c);
    bit acc, pp;
    int unsigned exp_rd;
    dout_vld  = v;
    dout_data = DW'(d);
    rd_en     = r;
    clr_stats = c;
    #1;
    exp_rd = (q.size() > 0) ? q[0] : 0;
    chk("busy", 32'(dout_busy), 32'(m_busy));
    chk("rd_vld", 32'(rd_vld), 32'(q.size() > 0));
    chk("rd_data", 32'(rd_data), exp_rd);
    chk("cnt", 32'(sample_cnt), m_cnt);
    chk("sum", 32'(acc_sum), 32'(m_sum));
    chk("ovf", 32'(sum_ovf), 32'(m_ovf));
    acc = v && !m_busy;
    pp  = r && (q.size() > 0);
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (c) model_clr();
    if (acc) begin
      q.push_back(d % (1 << DW));
      m_cnt = (m_cnt + 1) % 65536;
      m_sum = m_sum + (d % (1 << DW));
      if (m_sum >= (64'd1 << 24)) begin
        m_sum = m_sum - (64'd1 << 24);
        m_ovf = 1'b1;
      end
      n_acc++;
    end
    last_acc = acc;
    m_edges++;
    m_busy = (q.size() == DEPTH) ||
             (THR && (((m_edges - 1) % 2) == 1));
    @(negedge clk);
  endtask

  // Called at a negedge; reset takes effect with no clock edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(dout_busy), 32'd1);
    chk("rst_rd_vld", 32'(rd_vld), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_cnt", 32'(sample_cnt), 32'd0);
    chk("rst_sum", 32'(acc_sum), 32'd0);
    chk("rst_ovf", 32'(sum_ovf), 32'd0);
    q.delete();
    model_clr();
    m_busy  = 1'b1;
    m_edges = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int unsigned k;
    int guard;
    int unsigned d;
    rst       = 1'b0;
    dout_data = '0;
    dout_vld  = 1'b0;
    rd_en     = 1'b0;
    clr_stats = 1'b0;
    n_acc     = 0;
    @(negedge clk);
    do_reset();

    // Fill with 1..4, no reads
    k = 1;
    guard = 0;
    while (k <= 4 && guard < 20) begin
      cyc(1'b1, k, 1'b0, 1'b0);
      if (last_acc) k++;
      guard++;
    end
    chk("fill_done", 32'(k), 32'd5);
    chk("full_busy", 32'(dout_busy), 32'd1);
    chk("fill_cnt", 32'(sample_cnt), 32'd4);
    chk("fill_sum", 32'(acc_sum), 32'd10);

    // Pop at full with sample 5 waiting
    cyc(1'b1, 5, 1'b1, 1'b0);
    chk("pop_full_acc", 32'(last_acc), 32'd0);
    guard = 0;
    do begin
      cyc(1'b1, 5, 1'b0, 1'b0);
      guard++;
    end while (!last_acc && guard < 10);
    chk("five_acc", 32'(last_acc), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      chk("order", 32'(rd_data), 32'(i));
      cyc(1'b0, 0, 1'b1, 1'b0);
    end
    chk("drained", 32'(rd_vld), 32'd0);

    // Clear coinciding with an accepted sample
    guard = 0;
    while (m_busy && guard < 4) begin
      cyc(1'b0, 0, 1'b0, 1'b0);
      guard++;
    end
    cyc(1'b1, 5, 1'b0, 1'b1);
    chk("clr_cnt", 32'(sample_cnt), 32'd1);
    chk("clr_sum", 32'(acc_sum), 32'd5);
    chk("clr_ovf", 32'(sum_ovf), 32'd0);
    chk("clr_lvl", 32'(rd_vld), 32'd1);
    cyc(1'b0, 0, 1'b1, 1'b1);

    // Preload sum to 0xFFFFFE, then wrap it
    guard = 0;
    while (m_sum != 64'hFFFFFE && guard < 20000) begin
      d = ((64'hFFFFFE - m_sum) >= 64'h7FF) ?
          32'h7FF : 32'(64'hFFFFFE - m_sum);
      cyc(1'b1, d, 1'b1, 1'b0);
      guard++;
    end
    chk("preload", 32'(acc_sum), 32'hFFFFFE);
    guard = 0;
    do begin
      cyc(1'b1, 32'h7FF, 1'b1, 1'b0);
      guard++;
    end while (!last_acc && guard < 4);
    chk("wrap_sum", 32'(acc_sum), 32'h0007FD);
    chk("wrap_ovf", 32'(sum_ovf), 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 3, 1'b1, 1'b0);
    chk("ovf_sticky", 32'(sum_ovf), 32'd1);

    // Reset mid-transfer with level 3
    cyc(1'b0, 0, 1'b1, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b0);
    guard = 0;
    while (q.size() < 3 && guard < 20) begin
      cyc(1'b1, $urandom_range(0, 2047), 1'b0, 1'b0);
      guard++;
    end
    chk("lvl3", 32'(q.size()), 32'd3);
    do_reset();
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("post_rst_vld", 32'(rd_vld), 32'd0);
    chk("post_rst_cnt", 32'(sample_cnt), 32'd0);

`ifdef FIR_SINK_THROTTLE_EN
    do_reset();
    n_acc = 0;
    for (int i = 1; i <= 8; i++) cyc(1'b1, i, 1'b1, 1'b0);
    chk("thr_acc", 32'(n_acc), 32'd4);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          $urandom_range(0, 2047),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
